// File: rtl/apb_pad_cfg_loader.sv
// apb_pad_cfg_loader
// Boot-time APB write master: walks a configuration table through a
// 1-cycle-latency read port and issues one APB write per entry into the
// SoC control block. Reports completion or the first failing entry.
// All outputs are registered; they are computed from the next FSM state so
// that they line up with the state register.

module apb_pad_cfg_loader #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TABLE_AW       = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int AUTO_START     = 1
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      start_i,
    output logic                      tbl_rd_o,
    output logic [TABLE_AW-1:0]       tbl_idx_o,
    input  logic [APB_ADDR_WIDTH-1:0] tbl_addr_i,
    input  logic [31:0]               tbl_data_i,
    input  logic                      tbl_last_i,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o,
    output logic [TABLE_AW-1:0]       err_idx_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_SETUP  = 3'd3,
        ST_ACCESS = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [TABLE_AW-1:0] IDX_MAX  = {TABLE_AW{1'b1}};
    localparam logic [TABLE_AW-1:0] IDX_ZERO = {TABLE_AW{1'b0}};
    localparam logic [TABLE_AW-1:0] IDX_ONE  = {{(TABLE_AW-1){1'b0}}, 1'b1};
    localparam logic [15:0]         TMO_LIM  = 16'(TIMEOUT_CYCLES);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SLVERR  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // The APB select phase covers SETUP and ACCESS only.
    function automatic logic is_bus_state(input state_t st);
        return (st == ST_SETUP) || (st == ST_ACCESS);
    endfunction

    // A run is in progress from the table fetch until the transfer ends.
    function automatic logic is_busy_state(input state_t st);
        return (st == ST_FETCH) || (st == ST_LATCH) ||
               (st == ST_SETUP) || (st == ST_ACCESS);
    endfunction

    state_t                    state_r;
    state_t                    state_s;
    logic [TABLE_AW-1:0]       idx_r;
    logic [TABLE_AW-1:0]       idx_s;
    logic [15:0]               cnt_r;
    logic [15:0]               cnt_s;
    logic                      last_r;
    logic                      first_r;
    logic                      start_run_s;
    logic [1:0]                err_code_r;
    logic [1:0]                err_code_s;
    logic [TABLE_AW-1:0]       err_idx_r;
    logic [TABLE_AW-1:0]       err_idx_s;
    logic [APB_ADDR_WIDTH-1:0] paddr_r;
    logic [31:0]               pwdata_r;
    logic                      psel_r;
    logic                      penable_r;
    logic                      pwrite_r;
    logic                      tbl_rd_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      err_r;

    // Decide whether a new run starts this cycle: auto-start only in the
    // first cycle after reset (where start_i is ignored), otherwise start_i
    // when not busy.
    always_comb begin
        start_run_s = 1'b0;
        if ((state_r == ST_IDLE) && first_r) begin
            if (AUTO_START != 0) begin
                start_run_s = 1'b1;
            end else begin
                start_run_s = 1'b0;
            end
        end else if ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                     (state_r == ST_ERROR)) begin
            start_run_s = start_i;
        end else begin
            start_run_s = 1'b0;
        end
    end

    // Next-state, index, timeout counter and error bookkeeping.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        cnt_s      = cnt_r;
        err_code_s = err_code_r;
        err_idx_s  = err_idx_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_run_s) begin
                    state_s    = ST_FETCH;
                    idx_s      = IDX_ZERO;
                    err_code_s = ERR_NONE;
                    err_idx_s  = IDX_ZERO;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                state_s = ST_LATCH;
            end
            ST_LATCH: begin
                state_s = ST_SETUP;
            end
            ST_SETUP: begin
                cnt_s   = 16'd0;
                state_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_s    = ST_ERROR;
                        err_code_s = ERR_SLVERR;
                        err_idx_s  = idx_r;
                    end else if (last_r || (idx_r == IDX_MAX)) begin
                        state_s = ST_DONE;
                    end else begin
                        idx_s   = idx_r + IDX_ONE;
                        state_s = ST_FETCH;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                    if (cnt_s == TMO_LIM) begin
                        state_s    = ST_ERROR;
                        err_code_s = ERR_TIMEOUT;
                        err_idx_s  = idx_r;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, index, counter and error registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r    <= ST_IDLE;
            idx_r      <= IDX_ZERO;
            cnt_r      <= 16'd0;
            err_code_r <= ERR_NONE;
            err_idx_r  <= IDX_ZERO;
            first_r    <= 1'b1;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            cnt_r      <= cnt_s;
            err_code_r <= err_code_s;
            err_idx_r  <= err_idx_s;
            first_r    <= 1'b0;
        end
    end

    // Capture the table entry in LATCH; address/data then stay stable
    // through SETUP and ACCESS and keep their value while the bus is idle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            paddr_r  <= {APB_ADDR_WIDTH{1'b0}};
            pwdata_r <= 32'd0;
            last_r   <= 1'b0;
        end else if (state_r == ST_LATCH) begin
            paddr_r  <= tbl_addr_i;
            pwdata_r <= tbl_data_i;
            last_r   <= tbl_last_i;
        end
    end

    // Registered control outputs decoded from the next state.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            tbl_rd_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            psel_r    <= is_bus_state(state_s);
            penable_r <= (state_s == ST_ACCESS);
            pwrite_r  <= is_bus_state(state_s);
            tbl_rd_r  <= (state_s == ST_FETCH);
            busy_r    <= is_busy_state(state_s);
            done_r    <= (state_s == ST_DONE);
            err_r     <= (state_s == ST_ERROR);
        end
    end

    assign tbl_rd_o   = tbl_rd_r;
    assign tbl_idx_o  = idx_r;
    assign PADDR      = paddr_r;
    assign PWDATA     = pwdata_r;
    assign PWRITE     = pwrite_r;
    assign PSEL       = psel_r;
    assign PENABLE    = penable_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign err_o      = err_r;
    assign err_code_o = err_code_r;
    assign err_idx_o  = err_idx_r;

endmodule

// File: tb/tb_apb_pad_cfg_loader.sv
// Self-checking bench for apb_pad_cfg_loader: table responder, APB slave
// with programmable wait/error/stuck behaviour, and a write scoreboard.

module tb_apb_pad_cfg_loader;

    localparam int AW  = 12;
    localparam int TAW = 2;

    logic            HCLK;
    logic            HRESET;
    logic            start_i;
    logic            tbl_rd_o;
    logic [TAW-1:0]  tbl_idx_o;
    logic [AW-1:0]   tbl_addr_i;
    logic [31:0]     tbl_data_i;
    logic            tbl_last_i;
    logic [AW-1:0]   PADDR;
    logic [31:0]     PWDATA;
    logic            PWRITE;
    logic            PSEL;
    logic            PENABLE;
    logic            PREADY;
    logic            PSLVERR;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    logic [1:0]      err_code_o;
    logic [TAW-1:0]  err_idx_o;

    apb_pad_cfg_loader #(
        .APB_ADDR_WIDTH(AW),
        .TABLE_AW      (TAW),
        .TIMEOUT_CYCLES(8),
        .AUTO_START    (1)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .start_i   (start_i),
        .tbl_rd_o  (tbl_rd_o),
        .tbl_idx_o (tbl_idx_o),
        .tbl_addr_i(tbl_addr_i),
        .tbl_data_i(tbl_data_i),
        .tbl_last_i(tbl_last_i),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .err_code_o(err_code_o),
        .err_idx_o (err_idx_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [63:0] act,
                               input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Boot table model.
    logic [AW-1:0] t_addr [4];
    logic [31:0]   t_data [4];
    logic          t_last [4];

    // One-cycle-latency table read port.
    always @(posedge HCLK) begin
        if (tbl_rd_o) begin
            tbl_addr_i <= t_addr[tbl_idx_o];
            tbl_data_i <= t_data[tbl_idx_o];
            tbl_last_i <= t_last[tbl_idx_o];
        end
    end

    // APB slave model.
    logic          stuck;
    logic          err_en;
    logic [AW-1:0] err_addr;
    logic [AW-1:0] wait_addr;
    int            slv_wait;
    int            wcnt;

    // Count wait cycles of the current ACCESS phase.
    always @(posedge HCLK) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
    end

    assign PREADY  = !stuck && ((PADDR != wait_addr) || (wcnt >= slv_wait));
    assign PSLVERR = err_en && (PADDR == err_addr);

    // Cycle counter relative to reset release.
    int cyc;
    always @(posedge HCLK) begin
        if (HRESET) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];

    int n_acc;
    int n_wait;

    task automatic push_exp(input int i, input int c);
        exp_t e;
        e.addr = t_addr[i];
        e.data = t_data[i];
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Scoreboard: compare each ACCESS cycle against the oldest expected write.
    always @(negedge HCLK) begin
        exp_t e;
        if (!HRESET && PSEL && PENABLE) begin
            n_acc++;
            if (!PREADY) n_wait++;
            if (exp_q.size() == 0) begin
                check_value("wr_pending", 64'(exp_q.size()), 64'd1);
            end else if (PREADY) begin
                e = exp_q.pop_front();
                check_value("wr_addr", 64'(PADDR), 64'(e.addr));
                check_value("wr_data", 64'(PWDATA), 64'(e.data));
                check_value("wr_pwrite", 64'(PWRITE), 64'd1);
                if (e.cyc != 0) check_value("wr_cycle", 64'(cyc), 64'(e.cyc));
            end else begin
                e = exp_q[0];
                check_value("wait_addr_stable", 64'(PADDR), 64'(e.addr));
                check_value("wait_data_stable", 64'(PWDATA), 64'(e.data));
            end
        end
    end

    task automatic pulse_start();
        @(negedge HCLK);
        start_i = 1'b1;
        @(negedge HCLK);
        start_i = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (!(done_o || err_o) && k < 300) begin
            @(negedge HCLK);
            k++;
        end
        check_value({tag, "_bound"}, 64'(done_o || err_o), 64'd1);
    endtask

    task automatic set_entry(input int i, input logic [AW-1:0] a,
                             input logic [31:0] d, input logic l);
        t_addr[i] = a;
        t_data[i] = d;
        t_last[i] = l;
    endtask

    // Overall time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESET    = 1'b1;
        start_i   = 1'b0;
        stuck     = 1'b0;
        err_en    = 1'b0;
        err_addr  = 12'h000;
        wait_addr = 12'hFFF;
        slv_wait  = 0;
        set_entry(0, 12'h000, 32'h0000_00FF, 1'b0);
        set_entry(1, 12'h008, 32'h0001_0000, 1'b0);
        set_entry(2, 12'h020, 32'h1F1F_1F1F, 1'b1);
        set_entry(3, 12'h0FC, 32'hDEAD_BEEF, 1'b0);

        // Reset state.
        repeat (3) @(negedge HCLK);
        check_value("rst_outputs",
                    64'({tbl_rd_o, tbl_idx_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                         busy_o, done_o, err_o, err_code_o, err_idx_o}), 64'd0);

        // Test 1: auto-start, three entries, 4 cycles apart, done in cycle 13.
        push_exp(0, 4);
        push_exp(1, 8);
        push_exp(2, 12);
        HRESET = 1'b0;
        wait_end("t1");
        check_value("t1_done_cycle", 64'(cyc), 64'd13);
        check_value("t1_flags", 64'({busy_o, done_o, err_o}), 64'b010);
        check_value("t1_left", 64'(exp_q.size()), 64'd0);
        check_value("t1_psel_idle", 64'({PSEL, PENABLE, PWRITE}), 64'd0);

        // Test 2: entry 1 waits 5 cycles.
        wait_addr = 12'h008;
        slv_wait  = 5;
        n_wait    = 0;
        push_exp(0, 0);
        push_exp(1, 0);
        push_exp(2, 0);
        pulse_start();
        check_value("t2_restart", 64'({busy_o, done_o}), 64'b10);
        wait_end("t2");
        check_value("t2_waits", 64'(n_wait), 64'd5);
        check_value("t2_done", 64'({done_o, err_o}), 64'b10);
        check_value("t2_left", 64'(exp_q.size()), 64'd0);
        slv_wait = 0;

        // Test 3: PSLVERR on entry 1; entry 2 must not be issued.
        err_en   = 1'b1;
        err_addr = 12'h008;
        push_exp(0, 0);
        push_exp(1, 0);
        pulse_start();
        wait_end("t3");
        check_value("t3_err", 64'({done_o, err_o, err_code_o, err_idx_o}),
                    64'({1'b0, 1'b1, 2'b01, 2'd1}));
        repeat (6) @(negedge HCLK);
        check_value("t3_left", 64'(exp_q.size()), 64'd0);
        check_value("t3_idle", 64'({PSEL, busy_o}), 64'd0);
        err_en = 1'b0;

        // Test 4: stuck slave times out after 8 ACCESS cycles.
        stuck = 1'b1;
        n_acc = 0;
        push_exp(0, 0);
        pulse_start();
        check_value("t4_err_cleared", 64'({err_o, err_code_o, err_idx_o}), 64'd0);
        wait_end("t4");
        check_value("t4_acc_cycles", 64'(n_acc), 64'd8);
        check_value("t4_err", 64'({err_o, err_code_o, err_idx_o}),
                    64'({1'b1, 2'b10, 2'd0}));
        check_value("t4_psel_drop", 64'({PSEL, PENABLE}), 64'd0);
        check_value("t4_pending", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        stuck = 1'b0;

        // Test 5: no last flag -> all 4 entries, twice.
        set_entry(0, 12'h100, 32'hA5A5_0001, 1'b0);
        set_entry(1, 12'h104, 32'h5A5A_0002, 1'b0);
        set_entry(2, 12'h108, 32'h0F0F_0003, 1'b0);
        set_entry(3, 12'h10C, 32'hF0F0_0004, 1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) push_exp(i, 0);
            pulse_start();
            check_value("t5_done_clr", 64'({done_o, err_o, busy_o}), 64'b001);
            wait_end("t5");
            check_value("t5_done", 64'({done_o, err_o}), 64'b10);
            check_value("t5_left", 64'(exp_q.size()), 64'd0);
        end

        // Test 6a: start_i while busy is ignored.
        wait_addr = 12'h104;
        slv_wait  = 5;
        for (int i = 0; i < 4; i++) push_exp(i, 0);
        pulse_start();
        begin
            int k;
            k = 0;
            while (!(PSEL && PENABLE && !PREADY) && k < 50) begin
                @(negedge HCLK);
                k++;
            end
            check_value("t6_wait_seen", 64'(PSEL && PENABLE && !PREADY), 64'd1);
        end
        start_i = 1'b1;
        @(negedge HCLK);
        start_i = 1'b0;
        check_value("t6_busy_ignore", 64'({PSEL, PENABLE, tbl_rd_o, tbl_idx_o}),
                    64'({1'b1, 1'b1, 1'b0, 2'd1}));
        wait_end("t6a");
        check_value("t6a_left", 64'(exp_q.size()), 64'd0);
        slv_wait = 0;

        // Test 6b: asynchronous reset during ACCESS of entry 0.
        push_exp(0, 0);
        pulse_start();
        begin
            int k;
            k = 0;
            while (!(PSEL && PENABLE) && k < 50) begin
                @(negedge HCLK);
                k++;
            end
            check_value("t6_access_seen", 64'(PSEL && PENABLE), 64'd1);
        end
        #1 HRESET = 1'b1;
        #1;
        check_value("t6_async_rst",
                    64'({tbl_rd_o, tbl_idx_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                         busy_o, done_o, err_o, err_code_o, err_idx_o}), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge HCLK);
        for (int i = 0; i < 4; i++) push_exp(i, 4 * (i + 1));
        HRESET = 1'b0;
        wait_end("t6b");
        check_value("t6b_done", 64'({done_o, err_o, cyc}), 64'({1'b1, 1'b0, 32'd17}));
        check_value("t6b_left", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
